// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready handshake bundle between two pipeline stages around a pipe_stage_fifo.
// master = upstream producer / downstream consumer side, slave = the buffer itself.
interface pipe_stage_fifo_if #(
  parameter int DATA_W = 64
);
  logic              i_valid;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data
  );
endinterface

// File: rtl/pipe_stage_fifo.sv
// DEPTH-entry circular valid/ready buffer with synchronous flush and occupancy count.
// Optional macro PIPE_STAGE_FIFO_BUBBLE_EN forces o_data to BUBBLE while empty.
module pipe_stage_fifo #(
  parameter int              DATA_W = 64,
  parameter int              DEPTH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  pipe_stage_fifo_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              ins, rem;

  // Wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
  endfunction

  assign bus.i_ready = (count != CNT_W'(DEPTH));
  assign bus.o_valid = (count != '0);
  assign ins         = bus.i_valid & bus.i_ready;
  assign rem         = bus.o_valid & bus.o_ready;

`ifdef PIPE_STAGE_FIFO_BUBBLE_EN
  assign bus.o_data = bus.o_valid ? mem[rd_ptr] : BUBBLE;
`else
  assign bus.o_data = mem[rd_ptr];
`endif

  always_comb begin
    count_nxt  = count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (ins) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (rem) rd_ptr_nxt = ptr_inc(rd_ptr);
      case ({ins, rem})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count  <= count_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Payload storage carries no reset; a beat accepted during flush is dropped.
  always_ff @(posedge clk) begin
    if (ins && !flush) mem[wr_ptr] <= bus.i_data;
  end

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(DEPTH));
  a_no_remove_empty: assert property (@(posedge clk) disable iff (rst)
    !(bus.o_valid && bus.o_ready && count == '0));
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed scoreboard bench for pipe_stage_fifo (DEPTH=3, DATA_W=64, BUBBLE=0x13).
module tb_pipe_stage_fifo;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 3;
  localparam logic [DATA_W-1:0] BUBBLE = 64'h13;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [$clog2(DEPTH+1)-1:0] count;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] q [$];

  pipe_stage_fifo_if #(.DATA_W(DATA_W)) bus ();

  pipe_stage_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BUBBLE(BUBBLE)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: state checks, then handshake bookkeeping, between edges.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count_model", 64'(count), 64'(q.size()));
      chk("o_valid_model", 64'(bus.o_valid), 64'(q.size() != 0));
      chk("i_ready_model", 64'(bus.i_ready), 64'(q.size() != DEPTH));
`ifdef PIPE_STAGE_FIFO_BUBBLE_EN
      if (q.size() == 0) chk("bubble_model", bus.o_data, BUBBLE);
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (bus.o_valid && bus.o_ready && q.size() != 0) begin
          chk("o_data_order", bus.o_data, q[0]);
          void'(q.pop_front());
        end
        if (bus.i_valid && bus.i_ready) q.push_back(bus.i_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    bit acc = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.i_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("send_timeout", 64'(bus.i_ready), 64'd1);
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int k = 0; k < 30; k++) begin
      if (count == '0) break;
      step();
    end
    chk(tag, 64'(count), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.o_ready = 1'b0;
    step();
    step();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_o_valid", 64'(bus.o_valid), 64'd0);
    chk("reset_i_ready", 64'(bus.i_ready), 64'd1);
    rst = 1'b0;
    step();

    // Single beat through an empty buffer
    bus.o_ready = 1'b1;
    send(64'h8000_0000_0000_0013);
    chk("single_o_valid", 64'(bus.o_valid), 64'd1);
    chk("single_o_data", bus.o_data, 64'h8000_0000_0000_0013);
    step();
    chk("single_count_after", 64'(count), 64'd0);
    chk("single_o_valid_after", 64'(bus.o_valid), 64'd0);

    // Fill to full, hold off an extra beat, then drain in order
    bus.o_ready = 1'b0;
    send(64'h1);
    send(64'h2);
    send(64'h3);
    chk("full_count", 64'(count), 64'd3);
    chk("full_i_ready", 64'(bus.i_ready), 64'd0);
    bus.i_valid = 1'b1;
    bus.i_data  = 64'h4;
    step();
    step();
    chk("full_held_count", 64'(count), 64'd3);
    chk("full_head", bus.o_data, 64'h1);
    bus.o_ready = 1'b1;
    send(64'h4);
    wait_empty("fill_drain");

    // Streaming with pointer wrap
    bus.o_ready = 1'b1;
    send(64'd0);
    chk("stream_count_first", 64'(count), 64'd1);
    for (int i = 1; i < 10; i++) send(64'(i));
    chk("stream_last", bus.o_data, 64'd9);
    wait_empty("stream_drain");

    // Flush with a simultaneous push
    bus.o_ready = 1'b0;
    send(64'hA1);
    send(64'hA2);
    bus.i_valid = 1'b1;
    bus.i_data  = 64'hAA;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.i_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_o_valid", 64'(bus.o_valid), 64'd0);
    bus.o_ready = 1'b1;
    send(64'hBB);
    chk("flush_next_valid", 64'(bus.o_valid), 64'd1);
    chk("flush_next_data", bus.o_data, 64'hBB);
    wait_empty("flush_drain");

    // Asynchronous reset between edges
    bus.o_ready = 1'b0;
    send(64'hC1);
    send(64'hC2);
    chk("pre_rst_count", 64'(count), 64'd2);
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("async_rst_i_ready", 64'(bus.i_ready), 64'd1);
    step();
    rst = 1'b0;
    step();

    // Empty-buffer output
    chk("empty_o_valid", 64'(bus.o_valid), 64'd0);
`ifdef PIPE_STAGE_FIFO_BUBBLE_EN
    chk("empty_bubble", bus.o_data, BUBBLE);
`endif
    bus.o_ready = 1'b1;
    send(64'hD1);
    chk("post_rst_data", bus.o_data, 64'hD1);
    wait_empty("post_rst_drain");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
